axi4_lite_slv_reg_file: RTL and testbench

- AXI4-Lite slave exposing NUM_REGS read/write control registers of DATA_BIT_WIDTH bits each.
- Sits behind the AXI4-Lite interconnect. Connects to the slv_port side of the team's AXI4-Lite interface, with signals flattened here.
- Register contents are driven out in parallel to fabric logic.
- Write and read channels operate independently and concurrently.

---
 rtl/axi4_lite_slv_reg_file_if.sv | 38 +++
 rtl/axi4_lite_slv_reg_file.sv | 135 +++++++++++++
 tb/tb_axi4_lite_slv_reg_file.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bus bundle between an interconnect master and a register-file slave.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axi4_lite_slv_reg_file_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file: NUM_REGS byte-writable registers driven out in parallel.
// Define AXI4_LITE_SLV_REG_FILE_PRIV_WRITE_EN to reject unprivileged (awprot[0]=0) writes with SLVERR.
module axi4_lite_slv_reg_file #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  axi4_lite_slv_reg_file_if.slave            bus,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] regs_out
);

  localparam int STRB_W   = DATA_BIT_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rd_state_e;

  wr_state_e wr_state, wr_state_nxt;
  rd_state_e rd_state, rd_state_nxt;

  logic [DATA_BIT_WIDTH-1:0] regs [NUM_REGS];
  logic [1:0]                bresp_q;
  logic [1:0]                rresp_q;
  logic [DATA_BIT_WIDTH-1:0] rdata_q;

  logic [ADDR_BIT_WIDTH-1:0] aw_idx;
  logic [ADDR_BIT_WIDTH-1:0] ar_idx;
  logic [IDX_W-1:0]          aw_sel;
  logic [IDX_W-1:0]          ar_sel;
  logic                      aw_in_range;
  logic                      ar_in_range;
  logic                      wr_priv_ok;
  logic                      wr_ok;
  logic                      wr_en;

  // Index decode: low byte-offset bits are dropped, so unaligned addresses truncate.
  assign aw_idx      = bus.awaddr >> ADDR_LSB;
  assign ar_idx      = bus.araddr >> ADDR_LSB;
  assign aw_sel      = aw_idx[IDX_W-1:0];
  assign ar_sel      = ar_idx[IDX_W-1:0];
  assign aw_in_range = aw_idx < ADDR_BIT_WIDTH'(NUM_REGS);
  assign ar_in_range = ar_idx < ADDR_BIT_WIDTH'(NUM_REGS);

`ifdef AXI4_LITE_SLV_REG_FILE_PRIV_WRITE_EN
  assign wr_priv_ok = bus.awprot[0];
`else
  assign wr_priv_ok = 1'b1;
`endif

  assign wr_ok = aw_in_range && wr_priv_ok;
  assign wr_en = (wr_state == W_ACK) && wr_ok;

  // Protection on reads is ignored, and on writes unless the privilege option is built in.
  logic unused_bits;
  assign unused_bits = ^{bus.arprot, bus.awprot};

  // NOTE: state lives only in always_ff blocks with non-blocking assignments, so every
  // flop samples pre-edge values; this is what makes a same-cycle read return the old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // NOTE: next state takes its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_IDLE:  if (bus.awvalid && bus.wvalid) wr_state_nxt = W_ACK;
      W_ACK:   wr_state_nxt = W_RESP;
      W_RESP:  if (bus.bready) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (bus.arvalid) rd_state_nxt = R_ACK;
      R_ACK:   rd_state_nxt = R_RESP;
      R_RESP:  if (bus.rready) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // NOTE: the register array is reset explicitly because fabric logic consumes regs_out
  // directly and must see a defined zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) regs[aw_sel][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      if (wr_state == W_ACK) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (rd_state == R_ACK) begin
        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= ar_in_range ? regs[ar_sel] : '0;
      end
    end
  end

  assign bus.awready = (wr_state == W_ACK);
  assign bus.wready  = (wr_state == W_ACK);
  assign bus.bvalid  = (wr_state == W_RESP);
  assign bus.bresp   = bresp_q;
  assign bus.arready = (rd_state == R_ACK);
  assign bus.rvalid  = (rd_state == R_RESP);
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Self-checking bench for axi4_lite_slv_reg_file: directed steps plus randomized traffic
// compared against an array model of the register file.
module tb_axi4_lite_slv_reg_file;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 8;

`ifdef AXI4_LITE_SLV_REG_FILE_PRIV_WRITE_EN
  localparam bit PRIV_EN = 1'b1;
`else
  localparam bit PRIV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   regs_out;

  axi4_lite_slv_reg_file_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) bus ();

  axi4_lite_slv_reg_file #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .NUM_REGS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .regs_out (regs_out)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] model [N];

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] model_packed();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  // Reference write: returns the expected response and updates the model.
  function automatic logic [1:0] model_write(input logic [31:0] addr, data,
                                             input logic [3:0] strb, input logic [2:0] prot);
    int unsigned idx = addr / 4;
    logic [31:0] m;
    if (idx >= N) return 2'b10;
    if (PRIV_EN && !prot[0]) return 2'b10;
    m = strb_mask(strb);
    model[idx] = (model[idx] & ~m) | (data & m);
    return 2'b00;
  endfunction

  task automatic write_txn(input logic [31:0] addr, data, input logic [3:0] strb, input logic [2:0] prot);
    logic [1:0] exp_resp;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.awprot = prot;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    check("awready_pulse", bus.awready, 1);
    check("wready_pulse", bus.wready, 1);
    @(negedge clk);
    exp_resp = model_write(addr, data, strb, prot);
    check("awready_drop", bus.awready, 0);
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, exp_resp);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_clear", bus.bvalid, 0);
    check("regs_out", regs_out, model_packed());
  endtask

  task automatic read_txn(input logic [31:0] addr);
    int unsigned idx = addr / 4;
    @(negedge clk);
    bus.araddr = addr; bus.arprot = 3'($urandom_range(0, 7)); bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    check("arready_pulse", bus.arready, 1);
    check("rvalid_early", bus.rvalid, 0);
    @(negedge clk);
    check("arready_drop", bus.arready, 0);
    check("rvalid", bus.rvalid, 1);
    check("rdata", bus.rdata, (idx < N) ? model[idx] : 32'h0);
    check("rresp", bus.rresp, (idx < N) ? 2'b00 : 2'b10);
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_clear", bus.rvalid, 0);
  endtask

  initial begin
    logic [31:0] old_val;
    int pulses;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_regs", regs_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) read_txn(32'(i * 4));

    write_txn(32'h4, 32'hDEADBEEF, 4'hF, 3'b001);
    read_txn(32'h4);
    check("regs_out_reg1", regs_out[63:32], 32'hDEADBEEF);

    write_txn(32'h4, 32'h12345678, 4'b0101, 3'b001);
    read_txn(32'h4);
    check("partial_strobe", regs_out[63:32], 32'hDE34BE78);

    write_txn(32'(N * 4), 32'hCAFEF00D, 4'hF, 3'b001);
    read_txn(32'(N * 4));

    write_txn(32'h9, 32'h0BADC0DE, 4'hF, 3'b001);
    read_txn(32'hB);

    write_txn(32'hC, 32'h11223344, 4'hF, 3'b000);
    read_txn(32'hC);
    write_txn(32'hC, 32'h55667788, 4'hF, 3'b001);
    read_txn(32'hC);

    // Backpressure with a simultaneous read and write of the same register.
    @(negedge clk);
    old_val = model[2];
    bus.awaddr = 32'h8; bus.wdata = 32'hA5A50F0F; bus.wstrb = 4'hF; bus.awprot = 3'b001;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    bus.araddr = 32'h8; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    check("bp_awready", bus.awready, 1);
    check("bp_arready", bus.arready, 1);
    @(negedge clk);
    void'(model_write(32'h8, 32'hA5A50F0F, 4'hF, 3'b001));
    repeat (5) begin
      check("bp_bvalid_hold", bus.bvalid, 1);
      check("bp_bresp_hold", bus.bresp, 2'b00);
      check("bp_rvalid_hold", bus.rvalid, 1);
      check("bp_rdata_old", bus.rdata, old_val);
      check("bp_rresp_hold", bus.rresp, 2'b00);
      check("bp_no_awready", bus.awready, 0);
      check("bp_no_arready", bus.arready, 0);
      @(negedge clk);
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    check("bp_bvalid_clear", bus.bvalid, 0);
    check("bp_rvalid_clear", bus.rvalid, 0);
    check("bp_regs", regs_out, model_packed());

    // Back-to-back writes with bready held high: one accept every three cycles.
    @(negedge clk);
    bus.awaddr = 32'h1C; bus.wdata = 32'h600DF00D; bus.wstrb = 4'hF; bus.awprot = 3'b001;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.awready) pulses++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    void'(model_write(32'h1C, 32'h600DF00D, 4'hF, 3'b001));
    repeat (3) @(negedge clk);
    check("throughput_pulses", 256'(pulses), 3);
    check("throughput_regs", regs_out, model_packed());

    for (int t = 0; t < 30; t++) begin
      write_txn($urandom_range(0, (N + 3) * 4 - 1), $urandom, 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)));
      read_txn($urandom_range(0, (N + 3) * 4 - 1));
    end

    // Reset asserted on the handshake edge discards the write and its response.
    @(negedge clk);
    bus.awaddr = 32'h0; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.awprot = 3'b001;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    check("mid_awready", bus.awready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    for (int i = 0; i < N; i++) model[i] = 32'h0;
    check("mid_bvalid", bus.bvalid, 0);
    check("mid_awready_clr", bus.awready, 0);
    check("mid_regs", regs_out, 0);
    read_txn(32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
